// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the I/D main-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 31;
  localparam int TMO_W          = 5;
  localparam int GRANT_W        = 16;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  output logic [GRANT_W-1:0] o_cnt
);

  logic [GRANT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_en && (r_cnt != {GRANT_W{1'b1}}))
      r_cnt <= r_cnt + GRANT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache miss/writeback traffic onto one memory port;
// D has priority, but I is forced through after STARVE_MAX consecutive D wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic               i_wr,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic               i_done,
  input  logic               d_req,
  input  logic               d_wr,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_done,
  output logic [DATA_W-1:0]  rdata,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_stall,
  input  logic               mem_done,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy,
  output logic               err,
  output logic [GRANT_W-1:0] i_grants,
  output logic [GRANT_W-1:0] d_grants
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  state_t             r_state;
  state_t             w_next;
  owner_t             r_own;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [SC_W-1:0]    r_starve;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_err;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic               w_any;
  logic               w_pick_d;
  logic               w_inc_i;
  logic               w_inc_d;

  assign w_any     = i_req | d_req;
  assign w_pick_d  = d_req && !(i_req && (r_starve == SC_W'(STARVE_MAX)));
  assign w_inc_d   = (r_state == IDLE) && w_any && w_pick_d;
  assign w_inc_i   = (r_state == IDLE) && w_any && !w_pick_d;
  assign w_tmo_inc = r_tmo + TMO_W'(1);
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_own    <= OWN_I;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_starve <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_own    <= w_pick_d ? OWN_D : OWN_I;
            r_wr     <= w_pick_d ? d_wr : i_wr;
            r_addr   <= w_pick_d ? d_addr : i_addr;
            r_wdata  <= w_pick_d ? d_wdata : i_wdata;
            // Only a D win over a waiting I counts toward starvation.
            r_starve <= (w_pick_d && i_req) ? r_starve + SC_W'(1) : '0;
          end
        end
        ISSUE: begin
          if (!mem_stall)
            r_tmo <= '0;
        end
        WAIT: begin
          if (mem_done) begin
            r_rdata <= r_wr ? '0 : mem_rdata;
          end else begin
            r_tmo <= w_tmo_inc;
            if (w_tmo_inc == TMO_W'(TIMEOUT))
              r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    rdata     = '0;
    unique case (r_state)
      IDLE:  if (w_any) w_next = ISSUE;
      ISSUE: if (!mem_stall) w_next = WAIT;
      WAIT: begin
        if (mem_done)
          w_next = RESP;
        else if (w_tmo_inc == TMO_W'(TIMEOUT))
          w_next = IDLE;
      end
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE) begin
      busy      = 1'b1;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
    end
    if (r_state == ISSUE) begin
      mem_rd = !r_wr;
      mem_wr = r_wr;
    end
    if (r_state == RESP) begin
      i_done = (r_own == OWN_I);
      d_done = (r_own == OWN_D);
      rdata  = r_rdata;
    end
  end

  sat_counter16 u_i_grants (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_inc_i),
    .o_cnt (i_grants)
  );

  sat_counter16 u_d_grants (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_inc_d),
    .o_cnt (d_grants)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a decision model queues expected memory
// transactions, a separate monitor checks strobes, done pulses and rdata.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 4;
  localparam int TMO  = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_wr, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_done, d_done;
  logic [DW-1:0] rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_stall, mem_done;
  logic [DW-1:0] mem_rdata;
  logic          busy, err;
  logic [15:0]   i_grants, d_grants;

  logic          sc_rst_n, sc_en;
  logic [15:0]   sc_cnt;
  bit            sat_done = 1'b0;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .busy(busy), .err(err),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  sat_counter16 u_sat (.clk(clk), .rst_n(sc_rst_n), .i_en(sc_en), .o_cnt(sc_cnt));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Memory contents as seen by the bench: a fixed function of the address.
  bit beef_mode = 1'b0;
  function automatic logic [15:0] rd_val(input logic [15:0] a);
    if (beef_mode) return 16'hBEEF;
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  // Memory responder
  int lat_min = 1, lat_max = 1, stall_left = 0;
  bit noresp = 1'b0, rnd_stall = 1'b0;
  int          r_cnt;
  logic [15:0] r_a;
  logic        r_w;
  initial begin
    r_cnt = 0; r_a = '0; r_w = 1'b0;
    mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_rdata = '0;
      if (mem_rd || mem_wr) begin
        if (stall_left > 0) begin
          mem_stall = 1'b1;
          stall_left--;
        end else if (rnd_stall && ($urandom_range(3, 0) == 0)) begin
          mem_stall = 1'b1;
        end else begin
          mem_stall = 1'b0;
        end
        if (!mem_stall) begin
          r_cnt = $urandom_range(lat_max, lat_min);
          r_a   = mem_addr;
          r_w   = mem_wr;
        end
      end else begin
        mem_stall = 1'b0;
        if (r_cnt > 0) begin
          r_cnt--;
          if (r_cnt == 0 && !noresp) begin
            mem_done  = 1'b1;
            mem_rdata = r_w ? 16'hDEAD : rd_val(r_a);
          end
        end
      end
    end
  end

  // Reference model: at each arbitration point, predict the winner.
  typedef struct packed {
    logic        own;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   m_starve = 0, m_ig = 0, m_dg = 0;

  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_starve = 0; m_ig = 0; m_dg = 0;
        exp_q.delete();
      end else if (!busy && (i_req || d_req)) begin
        if (d_req && !(i_req && m_starve == SMAX)) begin
          t = '{own: 1'b1, wr: d_wr, addr: d_addr, wdata: d_wdata};
          m_starve = i_req ? m_starve + 1 : 0;
          if (m_dg < 65535) m_dg++;
        end else begin
          t = '{own: 1'b0, wr: i_wr, addr: i_addr, wdata: i_wdata};
          m_starve = 0;
          if (m_ig < 65535) m_ig++;
        end
        exp_q.push_back(t);
      end
    end
  end

  // Monitor
  txn_t        cur;
  bit          have_cur = 1'b0, prev_strobe = 1'b0;
  int          strobe_len = 0, last_strobe_len = 0;
  int          n_idone = 0, n_ddone = 0, n_err = 0;
  int unsigned issue_cyc = 0, err_cyc = 0;
  bit          done_log[$];
  logic [15:0] last_rdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur = 1'b0; prev_strobe = 1'b0; strobe_len = 0;
      end else begin
        if (mem_rd || mem_wr) begin
          if (!prev_strobe) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              have_cur = 1'b1;
            end
            strobe_len = 0;
          end
          strobe_len++;
          issue_cyc = cyc;
          if (have_cur) begin
            check("mem_addr", 32'(mem_addr), 32'(cur.addr));
            check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
            check("mem_wr", 32'(mem_wr), 32'(cur.wr));
            check("mem_rd", 32'(mem_rd), 32'(!cur.wr));
          end
        end else begin
          if (prev_strobe) last_strobe_len = strobe_len;
          if (busy && have_cur) check("addr_hold", 32'(mem_addr), 32'(cur.addr));
          if (!busy) check("idle_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
        end
        prev_strobe = mem_rd || mem_wr;

        if (i_done || d_done) begin
          check("done_onehot", 32'(i_done & d_done), 32'd0);
          check("done_has_txn", 32'(have_cur), 32'd1);
          if (have_cur) begin
            check("done_owner", 32'(d_done), 32'(cur.own));
            check("rdata", 32'(rdata), cur.wr ? 32'd0 : 32'(rd_val(cur.addr)));
            have_cur = 1'b0;
          end
          done_log.push_back(d_done);
          if (d_done) n_ddone++; else n_idone++;
          last_rdata = rdata;
        end else begin
          check("rdata_quiet", 32'(rdata), 32'd0);
        end

        if (err) begin
          n_err++;
          err_cyc = cyc;
          check("err_expected", 32'(noresp), 32'd1);
          check("err_no_done", 32'(i_done | d_done), 32'd0);
          have_cur = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit is_d, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    int t = 0;
    if (is_d) begin d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd; end
    else      begin i_req = 1'b1; i_wr = wr; i_addr = a; i_wdata = wd; end
    do begin
      @(posedge clk); #1;
      t++;
    end while (!(is_d ? d_done : i_done) && t < 300);
    check("done_seen", 32'(t < 300), 32'd1);
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic run_req(input bit is_d, input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin @(posedge clk); #1; end
      issue(is_d, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Saturation of the grant counter, run alongside the arbiter tests.
  initial begin
    sc_rst_n = 1'b1; sc_en = 1'b0;
    #1 sc_rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("sat_reset", 32'(sc_cnt), 32'd0);
    sc_rst_n = 1'b1; sc_en = 1'b1;
    repeat (65534) @(posedge clk); #1;
    check("sat_fffe", 32'(sc_cnt), 32'hFFFE);
    @(posedge clk); #1;
    check("sat_ffff", 32'(sc_cnt), 32'hFFFF);
    repeat (2) @(posedge clk); #1;
    check("sat_hold", 32'(sc_cnt), 32'hFFFF);
    sc_en = 1'b0;
    sat_done = 1'b1;
  end

  initial begin
    int t;
    int e0, d0;
    bit exp_order[6];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    i_req = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    check("rst_done_err", 32'({i_done, d_done, err}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_grants", 32'({i_grants, d_grants}), 32'd0);
    rst = 1'b1;

    // Single I read
    beef_mode = 1'b1; lat_min = 2; lat_max = 2;
    issue(1'b0, 1'b0, 16'h0040, 16'h0000);
    check("t1_rd_len", 32'(last_strobe_len), 32'd1);
    check("t1_idone", 32'(n_idone), 32'd1);
    check("t1_rdata", 32'(last_rdata), 32'hBEEF);
    check("t1_igrants", 32'(i_grants), 32'd1);
    beef_mode = 1'b0;

    // Starvation limit
    pulse_reset();
    done_log.delete();
    lat_min = 1; lat_max = 3;
    fork
      run_req(1'b1, 5, 0);
      run_req(1'b0, 1, 0);
    join
    check("t2_count", 32'(done_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < done_log.size(); k++)
      check("t2_order", 32'(done_log[k]), 32'(exp_order[k]));
    check("t2_dgrants", 32'(d_grants), 32'd5);
    check("t2_igrants", 32'(i_grants), 32'd1);

    // Stalled D write
    d0 = n_ddone;
    stall_left = 3;
    issue(1'b1, 1'b1, 16'h00A0, 16'h1234);
    check("t3_wr_len", 32'(last_strobe_len), 32'd4);
    check("t3_rdata", 32'(last_rdata), 32'd0);
    check("t3_ddone", 32'(n_ddone - d0), 32'd1);

    // Timeout abort
    e0 = n_err; d0 = n_idone + n_ddone;
    noresp = 1'b1;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0123; i_wdata = '0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!busy && t < 10);
    i_req = 1'b0;
    t = 0;
    while (n_err == e0 && t < 100) begin @(posedge clk); #1; t++; end
    check("t4_err_once", 32'(n_err - e0), 32'd1);
    check("t4_wait_cycles", 32'(err_cyc - issue_cyc), 32'd32);
    check("t4_no_done", 32'(n_idone + n_ddone), 32'(d0));
    check("t4_idle", 32'(busy), 32'd0);
    noresp = 1'b0;
    issue(1'b0, 1'b0, 16'h0077, 16'h0000);
    check("t4_recover", 32'(n_idone + n_ddone), 32'(d0 + 1));

    // Reset during WAIT
    lat_min = 20; lat_max = 20;
    e0 = n_err; d0 = n_idone + n_ddone;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0300; i_wdata = '0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!busy && t < 10);
    i_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_bus", 32'({mem_rd, mem_wr, mem_addr, mem_wdata}), 32'd0);
    check("t5_resp", 32'({i_done, d_done, err, rdata}), 32'd0);
    check("t5_grants", 32'({i_grants, d_grants}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (25) begin @(posedge clk); #1; end
    check("t5_no_done", 32'(n_idone + n_ddone), 32'(d0));
    check("t5_no_err", 32'(n_err), 32'(e0));
    check("t5_idle", 32'(busy), 32'd0);

    // Random traffic
    lat_min = 1; lat_max = 4; rnd_stall = 1'b1;
    fork
      run_req(1'b1, 40, 3);
      run_req(1'b0, 40, 3);
    join
    rnd_stall = 1'b0;
    check("t6_igrants", 32'(i_grants), 32'(m_ig));
    check("t6_dgrants", 32'(d_grants), 32'(m_dg));
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    t = 0;
    while (!sat_done && t < 80000) begin @(posedge clk); #1; t++; end
    check("sat_finished", 32'(sat_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified main-memory port between the instruction-cache and data-cache miss/writeback engines of the pipelined processor. Requests are serialized through a 4-state FSM. Data-cache requests have priority, bounded by a starvation limit that guarantees instruction-fetch progress. The block also keeps per-requester grant counters and a timeout error for the perf/debug logs.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced
TIMEOUT, 31, max cycles in WAIT before aborting (5-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_req  in  1  icache request, held until i_done
i_wr  in  1  icache write (0 = fill read)
i_addr  in  ADDR_W  icache address
i_wdata  in  DATA_W  icache write data
i_done  out  1  one-cycle completion pulse to icache
d_req  in  1  dcache request, held until d_done
d_wr  in  1  dcache write (writeback)
d_addr  in  ADDR_W  dcache address
d_wdata  in  DATA_W  dcache write data
d_done  out  1  one-cycle completion pulse to dcache
rdata  out  DATA_W  read data, valid only with i_done/d_done
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_stall  in  1  memory cannot accept a strobe this cycle
mem_done  in  1  memory completed access; mem_rdata valid
mem_rdata  in  DATA_W  memory read data
busy  out  1  FSM not in IDLE
err  out  1  one-cycle pulse on timeout abort
i_grants  out  16  saturating count of I transactions granted
d_grants  out  16  saturating count of D transactions granted

Behaviour:
- Reset (rst low, async): FSM=IDLE; all outputs 0; starve counter, timeout counter, grant counters and latched request registers 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: with any req high, select winner and latch owner, wr, addr, wdata into registers; go to ISSUE on the next edge; increment the winner's grant counter (saturates at 0xFFFF).
- Arbitration: only d_req -> D; only i_req -> I; both -> D unless starve_cnt == STARVE_MAX, then I.
- starve_cnt: increments when D wins while i_req is high; clears when I wins or i_req is low at the decision.
- ISSUE: drive mem_rd = ~wr or mem_wr = wr, plus mem_addr/mem_wdata from the latched registers.
  - mem_stall=1: stay in ISSUE and re-assert the strobe.
  - Otherwise: go to WAIT and clear the timeout counter.
- Strobes are high only in ISSUE. mem_addr and mem_wdata hold their latched values from ISSUE through RESP, and are 0 in IDLE.
- WAIT:
  - mem_done: capture mem_rdata (0 for writes); go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: pulse err, return to IDLE, no done pulse.
- RESP: pulse the owner's done for exactly one cycle with rdata valid; go to IDLE. rdata returns to 0 in the following cycle.
- Latency: req to done is at least 3 cycles plus memory latency (IDLE decision, ISSUE, WAIT >= 1 cycle, RESP). Back-to-back transactions have 1 IDLE cycle between them.
- Request inputs are ignored outside IDLE. A requester dropping req mid-transaction does not cancel it; done still pulses.
- mem_done outside WAIT is ignored.
- rst asserted mid-transaction aborts immediately with no done and no err. The memory's own reset is responsible for its state.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), owner encoding (OWN_I=1'b0, OWN_D=1'b1), default widths.
- Natural sub-module: sat_counter16 (enable, async active-low reset, saturating), instantiated twice for the grant counters.

Test Plan:
- Single I read at 0x0040; memory returns 0xBEEF 2 cycles after the strobe -> mem_rd for 1 cycle with mem_addr=0x0040; i_done pulses once with rdata=0xBEEF; i_grants=1.
- d_req and i_req together, each re-requesting immediately -> order D,D,D,D,I,D (STARVE_MAX=4); d_grants=5, i_grants=1 at that point.
- D write 0x1234 to 0x00A0 with mem_stall=1 for 3 cycles -> mem_wr high 4 cycles, addr/data stable; d_done pulses with rdata=0x0000.
- mem_done never asserted -> err pulses after 31 WAIT cycles; FSM returns to IDLE; no done; a following request completes normally.
- rst driven low during WAIT, then high -> all outputs 0 immediately; no done; grant counters read 0.
- Force 65537 I grants -> i_grants holds at 0xFFFF.
